// File: rtl/ctrl_pkg.sv
// Shared encodings for the control FSM and the DataPath benches:
// state codes, opcode field values and A-register source select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_START  = 4'b0000,
    S_FETCH  = 4'b0001,
    S_DECODE = 4'b0010,
    S_LOAD   = 4'b1000,
    S_STORE  = 4'b1001,
    S_ADD    = 4'b1010,
    S_SUB    = 4'b1011,
    S_INPUT  = 4'b1100,
    S_JZ     = 4'b1101,
    S_JPOS   = 4'b1110,
    S_HALT   = 4'b1111
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_INPUT = 3'b100,
    OP_JZ    = 3'b101,
    OP_JPOS  = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_RAM = 2'b10;

  // Execute states are laid out so that the code is the opcode with bit 3 set.
  function automatic state_t exec_state(input opcode_t op);
    return state_t'({1'b1, op});
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Bundle between the state register and the output decoder: current state and
// the datapath/operator qualifiers in, the full set of control strobes out.
interface control_fsm_if;
  import ctrl_pkg::*;

  state_t     state;
  logic       Enter;
  logic       Aeq0;
  logic       Apos;
  logic       IRload;
  logic       JMPmux;
  logic       PCload;
  logic       Meminst;
  logic       MemWr;
  logic [1:0] Asel;
  logic       Aload;
  logic       Sub;
  logic       halted;

  modport master (
    input  state, Enter, Aeq0, Apos,
    output IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, halted
  );

  modport slave (
    output state, Enter, Aeq0, Apos,
    input  IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, halted
  );

endinterface

// File: rtl/ctrl_out_decode.sv
// Combinational control-strobe decode from the current state; Enter, Aeq0 and
// Apos only qualify outputs in INPUT, JZ and JPOS respectively.
module ctrl_out_decode
  import ctrl_pkg::*;
(
  control_fsm_if.master bus
);

  always_comb begin
    bus.IRload  = 1'b0;
    bus.JMPmux  = 1'b0;
    bus.PCload  = 1'b0;
    bus.Meminst = 1'b0;
    bus.MemWr   = 1'b0;
    bus.Asel    = ASEL_ALU;
    bus.Aload   = 1'b0;
    bus.Sub     = 1'b0;
    bus.halted  = 1'b0;
    case (bus.state)
      S_FETCH: begin
        bus.IRload = 1'b1;
        bus.PCload = 1'b1;
      end
      S_DECODE: bus.Meminst = 1'b1;
      S_LOAD: begin
        bus.Asel  = ASEL_RAM;
        bus.Aload = 1'b1;
      end
      S_STORE: begin
        bus.Meminst = 1'b1;
        bus.MemWr   = 1'b1;
      end
      S_ADD: bus.Aload = 1'b1;
      S_SUB: begin
        bus.Aload = 1'b1;
        bus.Sub   = 1'b1;
      end
      S_INPUT: begin
        bus.Asel  = ASEL_IN;
        bus.Aload = bus.Enter;
      end
      S_JZ: begin
        bus.JMPmux = 1'b1;
        bus.PCload = bus.Aeq0;
      end
      S_JPOS: begin
        bus.JMPmux = 1'b1;
        bus.PCload = bus.Apos;
      end
      S_HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Instruction-sequencing FSM: START -> FETCH -> DECODE -> one execute state,
// with INPUT waiting on Enter and HALT parked until clear.
module control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic [2:0] IR75,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       Enter,
  output logic       IRload,
  output logic       JMPmux,
  output logic       PCload,
  output logic       Meminst,
  output logic       MemWr,
  output logic [1:0] Asel,
  output logic       Aload,
  output logic       Sub,
  output logic [3:0] state,
  output logic       halted
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (clear) state_q <= S_START;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = exec_state(opcode_t'(IR75));
      S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: state_d = S_START;
      S_INPUT:  if (Enter) state_d = S_START;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_START;
    endcase
  end

  control_fsm_if cif ();

  assign cif.state = state_q;
  assign cif.Enter = Enter;
  assign cif.Aeq0  = Aeq0;
  assign cif.Apos  = Apos;

  ctrl_out_decode u_dec (
    .bus (cif)
  );

  assign state   = state_q;
  assign IRload  = cif.IRload;
  assign JMPmux  = cif.JMPmux;
  assign PCload  = cif.PCload;
  assign Meminst = cif.Meminst;
  assign MemWr   = cif.MemWr;
  assign Asel    = cif.Asel;
  assign Aload   = cif.Aload;
  assign Sub     = cif.Sub;
  assign halted  = cif.halted;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: directed instruction scenarios with
// literal expectations plus a randomized run against an instruction-level model.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       clear;
  logic [2:0] ir75;
  logic [3:0] st;

  always #5 clk = ~clk;

  control_fsm_if tif ();

  control_fsm dut (
    .clk     (clk),
    .clear   (clear),
    .IR75    (ir75),
    .Aeq0    (tif.Aeq0),
    .Apos    (tif.Apos),
    .Enter   (tif.Enter),
    .IRload  (tif.IRload),
    .JMPmux  (tif.JMPmux),
    .PCload  (tif.PCload),
    .Meminst (tif.Meminst),
    .MemWr   (tif.MemWr),
    .Asel    (tif.Asel),
    .Aload   (tif.Aload),
    .Sub     (tif.Sub),
    .state   (st),
    .halted  (tif.halted)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       irload;
    logic       jmpmux;
    logic       pcload;
    logic       meminst;
    logic       memwr;
    logic [1:0] asel;
    logic       aload;
    logic       sub;
    logic       halted;
  } ov_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: step 0..2 = START/FETCH/DECODE, step 3 = executing opcode mop.
  int         mstep = 0;
  logic [2:0] mop   = 3'd0;
  bit         mvalid = 1'b0;

  function automatic ov_t model_out(int step, logic [2:0] op, logic en, logic aeq, logic apos);
    ov_t o = '0;
    case (step)
      0: ;
      1: begin o.st = 4'd1; o.irload = 1'b1; o.pcload = 1'b1; end
      2: begin o.st = 4'd2; o.meminst = 1'b1; end
      default: begin
        o.st = {1'b1, op};
        case (op)
          3'd0: begin o.asel = 2'b10; o.aload = 1'b1; end
          3'd1: begin o.meminst = 1'b1; o.memwr = 1'b1; end
          3'd2: o.aload = 1'b1;
          3'd3: begin o.aload = 1'b1; o.sub = 1'b1; end
          3'd4: begin o.asel = 2'b01; o.aload = en; end
          3'd5: begin o.jmpmux = 1'b1; o.pcload = aeq; end
          3'd6: begin o.jmpmux = 1'b1; o.pcload = apos; end
          default: o.halted = 1'b1;
        endcase
      end
    endcase
    return o;
  endfunction

  function automatic ov_t dut_out();
    ov_t o;
    o.st      = st;
    o.irload  = tif.IRload;
    o.jmpmux  = tif.JMPmux;
    o.pcload  = tif.PCload;
    o.meminst = tif.Meminst;
    o.memwr   = tif.MemWr;
    o.asel    = tif.Asel;
    o.aload   = tif.Aload;
    o.sub     = tif.Sub;
    o.halted  = tif.halted;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model mid-cycle,
  // then advance the model on the rising edge.
  task automatic tick(input logic clr, input logic [2:0] op, input logic en,
                      input logic aeq, input logic apos, output ov_t got);
    ov_t exp;
    clear    = clr;
    ir75     = op;
    tif.Enter = en;
    tif.Aeq0  = aeq;
    tif.Apos  = apos;
    @(negedge clk);
    got = dut_out();
    if (mvalid) begin
      exp = model_out(mstep, mop, en, aeq, apos);
      check("model", 32'(got), 32'(exp));
    end
    @(posedge clk);
    if (clr) begin
      mvalid = 1'b1;
      mstep  = 0;
    end else if (mvalid) begin
      case (mstep)
        0: mstep = 1;
        1: mstep = 2;
        2: begin mstep = 3; mop = op; end
        default: begin
          if (mop == 3'd7) mstep = 3;
          else if (mop == 3'd4 && !en) mstep = 3;
          else mstep = 0;
        end
      endcase
    end
    #1;
  endtask

  // Runs START, FETCH, DECODE(op) and the execute cycle from a START state.
  task automatic instr(input logic [2:0] op, input logic en, input logic aeq, input logic apos,
                       output ov_t s, output ov_t f, output ov_t d, output ov_t e);
    tick(1'b0, 3'd0, en, aeq, apos, s);
    tick(1'b0, 3'd0, en, aeq, apos, f);
    tick(1'b0, op,   en, aeq, apos, d);
    tick(1'b0, 3'd0, en, aeq, apos, e);
  endtask

  initial begin
    ov_t s, f, d, e, g;
    int cnt;
    int cnt2;

    clear = 1'b1; ir75 = 3'd0;
    tif.Enter = 1'b0; tif.Aeq0 = 1'b0; tif.Apos = 1'b0;

    tick(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, g);
    tick(1'b1, 3'd5, 1'b1, 1'b1, 1'b1, g);

    // LOAD right after reset
    instr(3'd0, 1'b0, 1'b0, 1'b0, s, f, d, e);
    check("reset_all_zero", 32'(s), 32'd0);
    check("reset_fetch_state", 32'(f.st), 32'd1);
    check("reset_fetch_irload_pcload", {f.irload, f.pcload}, 2'b11);
    check("reset_decode_state", 32'(d.st), 32'd2);
    check("decode_meminst", 32'(d.meminst), 32'd1);
    check("load_state", 32'(e.st), 32'h8);
    check("load_asel", 32'(e.asel), 32'h2);
    check("load_aload", 32'(e.aload), 32'd1);

    // STORE
    instr(3'd1, 1'b0, 1'b0, 1'b0, s, f, d, e);
    check("load_returns_start", 32'(s.st), 32'd0);
    check("store_state", 32'(e.st), 32'h9);
    check("store_meminst_memwr", {e.meminst, e.memwr}, 2'b11);
    cnt  = int'(s.memwr) + int'(f.memwr) + int'(d.memwr) + int'(e.memwr);
    cnt2 = int'(s.aload) + int'(f.aload) + int'(d.aload) + int'(e.aload);
    check("store_memwr_once", cnt, 1);
    check("store_no_aload", cnt2, 0);

    // INPUT with Enter low three cycles
    instr(3'd4, 1'b0, 1'b0, 1'b0, s, f, d, e);
    check("store_returns_start", 32'(s.st), 32'd0);
    cnt = 0;
    if (e.st == 4'hC && !e.aload) cnt++;
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, g);
      if (g.st == 4'hC && !g.aload) cnt++;
    end
    check("input_held_cycles", cnt, 3);
    tick(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, g);
    check("input_enter_state", 32'(g.st), 32'hC);
    check("input_enter_asel_aload", {g.asel, g.aload}, 3'b011);

    // JZ taken / not taken
    instr(3'd5, 1'b0, 1'b1, 1'b0, s, f, d, e);
    check("input_returns_start", 32'(s.st), 32'd0);
    check("jz_taken", {e.st, e.jmpmux, e.pcload}, 6'b1101_11);
    instr(3'd5, 1'b0, 1'b0, 1'b1, s, f, d, e);
    check("jz_not_taken", {e.st, e.jmpmux, e.pcload}, 6'b1101_10);

    // JPOS follows Apos even with the inconsistent Aeq0=Apos=1 pair
    instr(3'd6, 1'b0, 1'b1, 1'b1, s, f, d, e);
    check("jpos_both_flags", {e.st, e.jmpmux, e.pcload}, 6'b1110_11);
    instr(3'd6, 1'b0, 1'b1, 1'b0, s, f, d, e);
    check("jpos_not_taken", {e.st, e.jmpmux, e.pcload}, 6'b1110_10);

    // Enter held high through ADD, SUB and INPUT
    instr(3'd2, 1'b1, 1'b0, 1'b0, s, f, d, e);
    check("add_outputs", {e.st, e.asel, e.aload, e.sub}, 8'b1010_00_1_0);
    instr(3'd3, 1'b1, 1'b0, 1'b0, s, f, d, e);
    check("sub_outputs", {e.st, e.asel, e.aload, e.sub}, 8'b1011_00_1_1);
    instr(3'd4, 1'b1, 1'b0, 1'b0, s, f, d, e);
    check("input_held_enter", {e.st, e.aload}, 5'b1100_1);

    // HALT until clear
    instr(3'd7, 1'b1, 1'b0, 1'b0, s, f, d, e);
    check("input_held_enter_returns", 32'(s.st), 32'd0);
    cnt = (e.st == 4'hF && e.halted) ? 1 : 0;
    for (int i = 0; i < 11; i++) begin
      tick(1'b0, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom), g);
      if (g.st == 4'hF && g.halted) cnt++;
    end
    check("halt_cycles", cnt, 12);
    tick(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, g);
    check("halt_before_clear", 32'(g.st), 32'hF);
    tick(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, g);
    check("halt_clear_start", 32'(g), 32'd0);

    // clear during DECODE of a STORE
    tick(1'b0, 3'd1, 1'b0, 1'b0, 1'b0, g);
    tick(1'b0, 3'd1, 1'b0, 1'b0, 1'b0, g);
    tick(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, g);
    check("midop_in_decode", 32'(g.st), 32'd2);
    tick(1'b0, 3'd1, 1'b0, 1'b0, 1'b0, g);
    check("midop_clear_start", 32'(g), 32'd0);
    cnt = 0;
    tick(1'b0, 3'd2, 1'b0, 1'b0, 1'b0, g); cnt += int'(g.memwr);
    tick(1'b0, 3'd2, 1'b0, 1'b0, 1'b0, g); cnt += int'(g.memwr);
    tick(1'b0, 3'd2, 1'b0, 1'b0, 1'b0, g); cnt += int'(g.memwr);
    check("midop_no_memwr", cnt, 0);
    check("midop_next_is_add", 32'(g.st), 32'hA);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 24) == 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom), g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
